spy_memory_ctrl: RTL and testbench
==================================

Name: spy_memory_ctrl

Overview:
Parametrised next-generation spy buffer memory. Circular capture buffer with:
- programmable post-trigger freeze (RUN/DRAIN/FROZEN state machine);
- saturating occupancy, sticky wrap flag and one-cycle loop pulse;
- registered reads with a valid strobe.
Sits between the event stream tap and the spy readout logic. Readout fetches a frozen snapshot while upstream keeps streaming.

Parameters:
ADDR_WIDTH, 6, address bits; depth SIZE = 2**ADDR_WIDTH words.
DATA_WIDTH, 64, stored word width.

Ports:
clock  in  1  single system clock, all logic on rising edge.
reset  in  1  synchronous, active-low reset.
write_enable  in  1  write strobe from tapped stream.
write_data  in  DATA_WIDTH  word to capture.
read_enable  in  1  read request.
read_addr  in  ADDR_WIDTH  address to read.
read_data  out  DATA_WIDTH  registered read result.
read_valid  out  1  high one cycle after an accepted read.
freeze_req  in  1  one-cycle freeze trigger.
post_count  in  ADDR_WIDTH  words still captured after trigger; sampled on freeze_req.
unfreeze  in  1  one-cycle release back to RUN.
write_pointer  out  ADDR_WIDTH  next address to be written.
occupancy  out  ADDR_WIDTH+1  valid words stored, saturates at SIZE.
wrapped  out  1  sticky; set at first pointer wrap.
looped  out  1  one-cycle pulse on the write that wraps wptr SIZE-1 -> 0.
frozen  out  1  high in FROZEN.
freeze_pointer  out  ADDR_WIDTH  wptr value captured on entry to FROZEN.

Behaviour:
- Reset (reset=0 at clock edge) clears the following to 0, with state=RUN: wptr, occupancy, wrapped, looped, read_data, read_valid, frozen, freeze_pointer, drain counter.
- Reset does not clear memory contents. Reset mid-DRAIN or mid-FROZEN returns to RUN the same edge.
- Write acceptance: write accepted iff write_enable=1 and state is RUN or DRAIN.
  - Accepted write: memory[wptr] <= write_data; wptr <= wptr+1 (modulo SIZE).
  - Accepted write: occupancy <= min(occupancy+1, SIZE).
  - If wptr==SIZE-1: looped=1 next cycle (else 0), and wrapped <= 1.
- Writes in FROZEN are dropped: no memory, pointer or occupancy change.
- Reads accepted in any state. read_data <= memory[read_addr] and read_valid=1 one cycle later. With no read, read_valid=0 and read_data holds.
- Read and write to the same address in the same cycle: read returns the OLD contents (read-first).
- State machine:
  - RUN: on freeze_req with post_count==0 -> FROZEN. On freeze_req with post_count>0 -> DRAIN, with drain counter <= post_count.
  - RUN: a write in the freeze_req cycle is accepted and not counted.
  - DRAIN: each accepted write decrements the counter. The write taking it 1 -> 0 moves to FROZEN next cycle.
  - DRAIN: freeze_req ignored; unfreeze aborts to RUN and clears the counter.
  - FROZEN: freeze_pointer <= wptr on entry; frozen=1. unfreeze -> RUN. freeze_req ignored.
  - Simultaneous unfreeze and freeze_req in FROZEN: unfreeze wins, state=RUN, no new freeze.
  - Simultaneous freeze_req and unfreeze in RUN: freeze_req is handled, unfreeze ignored.
- occupancy and wrapped are not cleared by unfreeze; only reset clears them.
- Latencies: write to visible pointer change 1 cycle; read 1 cycle; freeze_req to frozen=1 is 1 cycle with post_count=0.

Decomposition:
- Package spy_pkg holds:
  - state enum {RUN, DRAIN, FROZEN} encoded 2 bits;
  - default ADDR_WIDTH/DATA_WIDTH constants;
  - helper constant for SIZE.
- One natural sub-module: spy_ram_1r1w, a simple dual-port read-first RAM (ADDR_WIDTH, DATA_WIDTH, registered read) coded for block-RAM inference. The control FSM, counters and flags stay in spy_memory_ctrl.

Test Plan:
Bench uses ADDR_WIDTH=3 (SIZE=8), DATA_WIDTH=16.
1. Write 0x0001..0x0009 (9 words), then read addr 0 -> read_data=0x0009 one cycle later with read_valid=1. occupancy=8, wrapped=1, looped pulsed exactly once (on the 8th write), write_pointer=1.
2. Write 3 words, freeze_req with post_count=2, then write 5 more -> only 2 more accepted. frozen=1, freeze_pointer=5, write_pointer=5, occupancy=5.
3. freeze_req with post_count=0 while write_enable=1 -> that write accepted. frozen=1 next cycle; further writes leave write_pointer unchanged.
4. In FROZEN assert unfreeze and freeze_req together -> frozen=0, state RUN. Next write advances write_pointer by 1.
5. Write 0xAAAA at addr 2, then in one cycle write 0xBBBB at addr 2 and read addr 2 -> read_data=0xAAAA. Re-read next cycle -> 0xBBBB.
6. Pulse reset=0 in DRAIN with counter=3 -> all outputs 0, state RUN. A read of a previously written address still returns its old data.

Source files
------------

// File: rtl/spy_pkg.sv
// Shared types and default sizing for the spy capture buffer.
package spy_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    FROZEN = 2'd2
  } spy_state_e;

  localparam int unsigned SPY_ADDR_WIDTH = 6;
  localparam int unsigned SPY_DATA_WIDTH = 64;

  function automatic int unsigned spy_size(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  localparam int unsigned SPY_SIZE = spy_size(SPY_ADDR_WIDTH);

endpackage

// File: rtl/spy_ram_1r1w.sv
// Simple dual-port read-first RAM with a registered read port, shaped for block-RAM inference.
module spy_ram_1r1w
  import spy_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SPY_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SPY_DATA_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned Depth = spy_size(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [Depth];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Array has no reset so contents survive a controller reset.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spy_memory_ctrl.sv
// Circular spy capture buffer: write pointer, occupancy and wrap flags, and the
// RUN/DRAIN/FROZEN post-trigger freeze machine around a read-first RAM.
module spy_memory_ctrl
  import spy_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SPY_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SPY_DATA_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_write_enable,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic                  i_read_enable,
  input  logic [ADDR_WIDTH-1:0] i_read_addr,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic                  o_read_valid,
  input  logic                  i_freeze_req,
  input  logic [ADDR_WIDTH-1:0] i_post_count,
  input  logic                  i_unfreeze,
  output logic [ADDR_WIDTH-1:0] o_write_pointer,
  output logic [ADDR_WIDTH:0]   o_occupancy,
  output logic                  o_wrapped,
  output logic                  o_looped,
  output logic                  o_frozen,
  output logic [ADDR_WIDTH-1:0] o_freeze_pointer
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;
  localparam logic [ADDR_WIDTH:0]   OccMax   = {1'b1, {ADDR_WIDTH{1'b0}}};

  spy_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH:0]   r_occupancy;
  logic                  r_wrapped;
  logic                  r_looped;
  logic                  r_read_valid;
  logic                  r_frozen;
  logic [ADDR_WIDTH-1:0] r_freeze_ptr;
  logic [ADDR_WIDTH-1:0] r_drain_cnt;

  logic                  w_wr_accept;
  logic [ADDR_WIDTH-1:0] w_wptr_next;

  // Writes are blocked while reset is asserted so the RAM only sees real captures.
  assign w_wr_accept = i_reset && i_write_enable && (r_state != FROZEN);
  assign w_wptr_next = w_wr_accept ? r_wptr + ADDR_WIDTH'(1) : r_wptr;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state      <= RUN;
      r_wptr       <= '0;
      r_occupancy  <= '0;
      r_wrapped    <= 1'b0;
      r_looped     <= 1'b0;
      r_read_valid <= 1'b0;
      r_frozen     <= 1'b0;
      r_freeze_ptr <= '0;
      r_drain_cnt  <= '0;
    end else begin
      r_read_valid <= i_read_enable;
      r_looped     <= 1'b0;
      if (w_wr_accept) begin
        r_wptr <= w_wptr_next;
        if (r_occupancy != OccMax) begin
          r_occupancy <= r_occupancy + (ADDR_WIDTH + 1)'(1);
        end
        if (r_wptr == LastAddr) begin
          r_looped  <= 1'b1;
          r_wrapped <= 1'b1;
        end
      end
      unique case (r_state)
        RUN: begin
          // The write in the trigger cycle is kept but does not consume post_count.
          if (i_freeze_req) begin
            if (i_post_count == '0) begin
              r_state      <= FROZEN;
              r_frozen     <= 1'b1;
              r_freeze_ptr <= w_wptr_next;
            end else begin
              r_state     <= DRAIN;
              r_drain_cnt <= i_post_count;
            end
          end
        end
        DRAIN: begin
          if (i_unfreeze) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
          end else if (w_wr_accept) begin
            r_drain_cnt <= r_drain_cnt - ADDR_WIDTH'(1);
            if (r_drain_cnt == ADDR_WIDTH'(1)) begin
              r_state      <= FROZEN;
              r_frozen     <= 1'b1;
              r_freeze_ptr <= w_wptr_next;
            end
          end
        end
        FROZEN: begin
          if (i_unfreeze) begin
            r_state  <= RUN;
            r_frozen <= 1'b0;
          end
        end
        default: begin
          r_state  <= RUN;
          r_frozen <= 1'b0;
        end
      endcase
    end
  end

  spy_ram_1r1w #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_we   (w_wr_accept),
    .i_waddr(r_wptr),
    .i_wdata(i_write_data),
    .i_re   (i_read_enable),
    .i_raddr(i_read_addr),
    .o_rdata(o_read_data)
  );

  assign o_read_valid     = r_read_valid;
  assign o_write_pointer  = r_wptr;
  assign o_occupancy      = r_occupancy;
  assign o_wrapped        = r_wrapped;
  assign o_looped         = r_looped;
  assign o_frozen         = r_frozen;
  assign o_freeze_pointer = r_freeze_ptr;

endmodule

// File: tb/tb_spy_memory_ctrl.sv
// Directed self-checking bench for spy_memory_ctrl with an 8-deep, 16-bit buffer.
module tb_spy_memory_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          write_enable;
  logic [DW-1:0] write_data;
  logic          read_enable;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic          read_valid;
  logic          freeze_req;
  logic [AW-1:0] post_count;
  logic          unfreeze;
  logic [AW-1:0] write_pointer;
  logic [AW:0]   occupancy;
  logic          wrapped;
  logic          looped;
  logic          frozen;
  logic [AW-1:0] freeze_pointer;

  int n_checks = 0;
  int n_errors = 0;
  int loop_cnt = 0;
  int loop_base;

  always #5 clk = ~clk;

  always @(negedge clk) if (looped) loop_cnt++;

  spy_memory_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .i_clock         (clk),
    .i_reset         (rst_n),
    .i_write_enable  (write_enable),
    .i_write_data    (write_data),
    .i_read_enable   (read_enable),
    .i_read_addr     (read_addr),
    .o_read_data     (read_data),
    .o_read_valid    (read_valid),
    .i_freeze_req    (freeze_req),
    .i_post_count    (post_count),
    .i_unfreeze      (unfreeze),
    .o_write_pointer (write_pointer),
    .o_occupancy     (occupancy),
    .o_wrapped       (wrapped),
    .o_looped        (looped),
    .o_frozen        (frozen),
    .o_freeze_pointer(freeze_pointer)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d);
    write_enable = 1'b1;
    write_data   = d;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    read_enable = 1'b1;
    read_addr   = a;
    tick();
    read_enable = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wptr"}, 32'(write_pointer), 0);
    check_eq({tag, "_occ"}, 32'(occupancy), 0);
    check_eq({tag, "_wrapped"}, 32'(wrapped), 0);
    check_eq({tag, "_looped"}, 32'(looped), 0);
    check_eq({tag, "_rdata"}, 32'(read_data), 0);
    check_eq({tag, "_rvalid"}, 32'(read_valid), 0);
    check_eq({tag, "_frozen"}, 32'(frozen), 0);
    check_eq({tag, "_fptr"}, 32'(freeze_pointer), 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    write_enable = 1'b0;
    write_data   = '0;
    read_enable  = 1'b0;
    read_addr    = '0;
    freeze_req   = 1'b0;
    post_count   = '0;
    unfreeze     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_all_zero("rst");

    // 1: nine writes wrap once; addr 0 ends up holding the ninth word
    loop_base = loop_cnt;
    for (int i = 1; i <= 7; i++) wr(DW'(i));
    check_eq("t1_no_loop_yet", 32'(looped), 0);
    wr(16'h0008);
    check_eq("t1_loop_pulse", 32'(looped), 1);
    check_eq("t1_wptr_wrap", 32'(write_pointer), 0);
    wr(16'h0009);
    check_eq("t1_loop_clear", 32'(looped), 0);
    rd(3'd0);
    check_eq("t1_rdata", 32'(read_data), 32'h0009);
    check_eq("t1_rvalid", 32'(read_valid), 1);
    check_eq("t1_occ_sat", 32'(occupancy), 8);
    check_eq("t1_wrapped", 32'(wrapped), 1);
    check_eq("t1_wptr", 32'(write_pointer), 1);
    tick();
    check_eq("t1_rvalid_drop", 32'(read_valid), 0);
    check_eq("t1_rdata_hold", 32'(read_data), 32'h0009);
    check_eq("t1_loop_count", 32'(loop_cnt - loop_base), 1);

    // 2: post_count=2 lets exactly two more writes in
    do_reset();
    for (int i = 0; i < 3; i++) wr(DW'(16'h0100 + i));
    freeze_req = 1'b1;
    post_count = 3'd2;
    tick();
    freeze_req = 1'b0;
    post_count = '0;
    check_eq("t2_draining", 32'(frozen), 0);
    wr(16'h0103);
    check_eq("t2_drain_1", 32'(frozen), 0);
    for (int i = 4; i < 8; i++) wr(DW'(16'h0100 + i));
    check_eq("t2_frozen", 32'(frozen), 1);
    check_eq("t2_fptr", 32'(freeze_pointer), 5);
    check_eq("t2_wptr", 32'(write_pointer), 5);
    check_eq("t2_occ", 32'(occupancy), 5);
    check_eq("t2_wrapped", 32'(wrapped), 0);

    // 3: immediate freeze keeps the trigger-cycle write, then blocks writes
    unfreeze = 1'b1;
    tick();
    unfreeze = 1'b0;
    check_eq("t3_unfrozen", 32'(frozen), 0);
    freeze_req   = 1'b1;
    write_enable = 1'b1;
    write_data   = 16'h0300;
    tick();
    freeze_req   = 1'b0;
    write_enable = 1'b0;
    check_eq("t3_frozen", 32'(frozen), 1);
    check_eq("t3_wptr", 32'(write_pointer), 6);
    check_eq("t3_fptr", 32'(freeze_pointer), 6);
    wr(16'h0301);
    wr(16'h0302);
    check_eq("t3_wptr_held", 32'(write_pointer), 6);
    check_eq("t3_occ_held", 32'(occupancy), 6);

    // 4: unfreeze beats a simultaneous freeze_req
    unfreeze   = 1'b1;
    freeze_req = 1'b1;
    tick();
    unfreeze   = 1'b0;
    freeze_req = 1'b0;
    check_eq("t4_unfrozen", 32'(frozen), 0);
    tick();
    check_eq("t4_stays_run", 32'(frozen), 0);
    wr(16'h0400);
    check_eq("t4_wptr", 32'(write_pointer), 7);

    // 5: read-first collision at address 2
    do_reset();
    wr(16'h5000);
    wr(16'h5001);
    wr(16'hAAAA);
    for (int i = 3; i < 10; i++) wr(DW'(16'h5000 + i));
    check_eq("t5_wptr_at_2", 32'(write_pointer), 2);
    write_enable = 1'b1;
    write_data   = 16'hBBBB;
    read_enable  = 1'b1;
    read_addr    = 3'd2;
    tick();
    write_enable = 1'b0;
    check_eq("t5_old_data", 32'(read_data), 32'hAAAA);
    tick();
    read_enable = 1'b0;
    check_eq("t5_new_data", 32'(read_data), 32'hBBBB);

    // 6: reset mid-DRAIN clears control state but keeps memory
    do_reset();
    wr(16'hC0DE);
    freeze_req = 1'b1;
    post_count = 3'd3;
    tick();
    freeze_req = 1'b0;
    post_count = '0;
    rd(3'd0);
    check_eq("t6_pre_rdata", 32'(read_data), 32'hC0DE);
    check_eq("t6_pre_frozen", 32'(frozen), 0);
    do_reset();
    check_all_zero("t6");
    rd(3'd2);
    check_eq("t6_mem_kept", 32'(read_data), 32'hBBBB);
    rd(3'd0);
    check_eq("t6_mem_kept0", 32'(read_data), 32'hC0DE);
    freeze_req = 1'b1;
    tick();
    freeze_req = 1'b0;
    check_eq("t6_run_freeze", 32'(frozen), 1);
    check_eq("t6_run_fptr", 32'(freeze_pointer), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
